vram_slot_arbiter: RTL and testbench

//  Parametrised successor to the fixed 4-way video RAM address mux: a single-port

---
 rtl/vram_slot_arbiter_pkg.sv | 7 +
 rtl/vram_slot_arbiter_if.sv | 28 ++
 rtl/vram_slot_arbiter_sp_ram.sv | 25 ++
 rtl/vram_slot_arbiter.sv | 67 ++++++
 tb/tb_vram_slot_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/vram_slot_arbiter_pkg.sv
// vram_pkg: shared slot/channel types for the video RAM slot arbiter.
package vram_pkg;
    localparam int NUM_CH_DEFAULT = 3;
    localparam int CPU_SLOT = 0;
    typedef logic [$clog2(NUM_CH_DEFAULT+1)-1:0] slot_t;
    typedef enum logic [1:0] {ALPHA, MO, PF} vid_ch_t;
endpackage

// File: rtl/vram_slot_arbiter_if.sv
// vram_slot_arbiter_if: CPU handshake, video fetch and slot signals of the arbiter.
interface vram_slot_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int NUM_CH = 3
);
    logic                         slot_sync;
    logic                         cpu_req;
    logic                         cpu_we;
    logic [ADDR_W-1:0]            cpu_addr;
    logic [DATA_W/8-1:0]          cpu_be;
    logic [DATA_W-1:0]            cpu_wdata;
    logic                         cpu_ack;
    logic [DATA_W-1:0]            cpu_rdata;
    logic [NUM_CH-1:0]            vid_en;
    logic [NUM_CH*ADDR_W-1:0]     vid_addr;
    logic [NUM_CH-1:0]            vid_valid;
    logic [DATA_W-1:0]            vid_rdata;
    logic [$clog2(NUM_CH+1)-1:0]  slot;
    modport master (
        output slot_sync, cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata, vid_en, vid_addr,
        input  cpu_ack, cpu_rdata, vid_valid, vid_rdata, slot
    );
    modport slave (
        input  slot_sync, cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata, vid_en, vid_addr,
        output cpu_ack, cpu_rdata, vid_valid, vid_rdata, slot
    );
endinterface

// File: rtl/vram_slot_arbiter_sp_ram.sv
// vram_sp_ram: single-port synchronous RAM, byte-enable writes, 1-cycle read latency.
module vram_sp_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DATA_W/8; i++)
                    if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/vram_slot_arbiter.sv
// vram_slot_arbiter: round-robin time-slot sharing of one video RAM between the CPU
// and NUM_CH video fetch channels, with tagged routing of the 1-cycle read return.
module vram_slot_arbiter
    import vram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int NUM_CH = 3
) (
    input logic clk,
    input logic rst,
    vram_slot_arbiter_if.slave bus
);
    localparam int SW = $clog2(NUM_CH+1);
    logic [SW-1:0]     slot_q, slot_d;
    logic              cpu_ack_q, cpu_rd_q, cpu_go, ram_en, ram_we;
    logic [NUM_CH-1:0] vid_tag_q, vid_hit;
    logic [ADDR_W-1:0] vid_addr_sel, ram_addr;
    logic [DATA_W-1:0] cpu_hold_q, vid_hold_q, ram_rdata;
    always_comb begin
        vid_hit = '0;
        vid_addr_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (slot_q == SW'(c + 1) && bus.vid_en[c]) begin
                vid_hit[c] = 1'b1;
                vid_addr_sel = bus.vid_addr[c*ADDR_W +: ADDR_W];
            end
        end
    end
    // A request still high during its own ack cycle must not re-issue.
    assign cpu_go   = slot_q == SW'(CPU_SLOT) && bus.cpu_req && !cpu_ack_q;
    assign slot_d   = (bus.slot_sync || slot_q == SW'(NUM_CH)) ? '0 : slot_q + 1'b1;
    assign ram_en   = !rst && (cpu_go || |vid_hit);
    assign ram_we   = cpu_go && bus.cpu_we;
    assign ram_addr = cpu_go ? bus.cpu_addr : vid_addr_sel;
    vram_sp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .be    (bus.cpu_be),
        .wdata (bus.cpu_wdata),
        .rdata (ram_rdata)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q     <= '0;
            cpu_ack_q  <= 1'b0;
            cpu_rd_q   <= 1'b0;
            vid_tag_q  <= '0;
            cpu_hold_q <= '0;
            vid_hold_q <= '0;
        end else begin
            slot_q    <= slot_d;
            cpu_ack_q <= cpu_go;
            cpu_rd_q  <= cpu_go && !bus.cpu_we;
            vid_tag_q <= vid_hit;
            if (cpu_rd_q) cpu_hold_q <= ram_rdata;
            if (|vid_tag_q) vid_hold_q <= ram_rdata;
        end
    end
    assign bus.slot      = slot_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rd_q ? ram_rdata : cpu_hold_q;
    assign bus.vid_valid = vid_tag_q;
    assign bus.vid_rdata = |vid_tag_q ? ram_rdata : vid_hold_q;
endmodule

// File: tb/tb_vram_slot_arbiter.sv
// tb_vram_slot_arbiter: directed checks of slot rotation, CPU handshake, byte enables,
// video fetch routing, slot resync and reset behaviour.
module tb_vram_slot_arbiter;
    import vram_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    vram_slot_arbiter_if #(.DATA_W(16), .ADDR_W(12), .NUM_CH(3)) bus ();
    vram_slot_arbiter #(.DATA_W(16), .ADDR_W(12), .NUM_CH(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_slot(input int s);
        int n = 0;
        while (int'(bus.slot) != s && n < 10) begin
            tick();
            n++;
        end
        if (int'(bus.slot) != s) begin
            tests++; fails++;
            $display("FAIL wait_slot: slot=%0d never reached %0d", bus.slot, s);
        end
    endtask

    // Issues one CPU access in slot 0 and returns what is seen in the following cycle.
    task automatic cpu_access(input logic we, input logic [11:0] addr, input logic [15:0] wd,
                              input logic [1:0] be, output logic ack, output logic [15:0] rd);
        wait_slot(0);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr;
        bus.cpu_wdata = wd; bus.cpu_be = be;
        tick();
        ack = bus.cpu_ack; rd = bus.cpu_rdata;
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        slot_t exp;
        rst = 1'b1;
        tick(); tick();
        tests++;
        if (bus.slot !== 2'd0 || bus.cpu_ack !== 1'b0 || bus.cpu_rdata !== 16'h0 ||
            bus.vid_valid !== 3'b0 || bus.vid_rdata !== 16'h0) begin
            fails++;
            $display("FAIL reset_state: slot=%0d ack=%b rdata=%h vvalid=%b vrdata=%h", bus.slot,
                     bus.cpu_ack, bus.cpu_rdata, bus.vid_valid, bus.vid_rdata);
        end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = slot_t'(i % 4);
            tests++;
            if (bus.slot !== exp || bus.cpu_ack !== 1'b0 || bus.vid_valid !== 3'b0) begin
                fails++;
                $display("FAIL slot_seq[%0d]: slot=%0d expected %0d ack=%b vvalid=%b", i, bus.slot,
                         exp, bus.cpu_ack, bus.vid_valid);
            end
        end
    endtask

    task automatic test_write_read();
        logic ack; logic [15:0] rd;
        cpu_access(1'b1, 12'h123, 16'hBEEF, 2'b11, ack, rd);
        tests++;
        if (ack !== 1'b1) begin fails++; $display("FAIL write_ack: got %b expected 1", ack); end
        tick();
        tests++;
        if (bus.cpu_ack !== 1'b0) begin fails++; $display("FAIL ack_pulse: got %b expected 0", bus.cpu_ack); end
        cpu_access(1'b0, 12'h123, 16'h0, 2'b00, ack, rd);
        tests++;
        if (ack !== 1'b1 || rd !== 16'hBEEF) begin
            fails++; $display("FAIL read_beef: ack=%b rdata=%h expected 1/beef", ack, rd);
        end
    endtask

    task automatic test_byte_enable();
        logic ack; logic [15:0] rd;
        cpu_access(1'b1, 12'h123, 16'h00AA, 2'b01, ack, rd);
        tests++;
        if (ack !== 1'b1 || rd !== 16'hBEEF) begin
            fails++; $display("FAIL write_keeps_rdata: ack=%b rdata=%h expected 1/beef", ack, rd);
        end
        cpu_access(1'b1, 12'h123, 16'h1234, 2'b00, ack, rd);
        tests++;
        if (ack !== 1'b1) begin fails++; $display("FAIL be0_ack: got %b expected 1", ack); end
        cpu_access(1'b0, 12'h123, 16'h0, 2'b00, ack, rd);
        tests++;
        if (rd !== 16'hBEAA) begin fails++; $display("FAIL byte_merge: rdata=%h expected beaa", rd); end
    endtask

    task automatic test_video();
        logic ack; logic [15:0] rd;
        logic [2:0]  exp_v [3] = '{3'b001, 3'b010, 3'b100};
        logic [15:0] exp_d [3] = '{16'h1111, 16'hBEAA, 16'h2222};
        cpu_access(1'b1, 12'h010, 16'h1111, 2'b11, ack, rd);
        cpu_access(1'b1, 12'h020, 16'h2222, 2'b11, ack, rd);
        bus.vid_addr[int'(ALPHA)*12 +: 12] = 12'h010;
        bus.vid_addr[int'(MO)*12 +: 12]    = 12'h123;
        bus.vid_addr[int'(PF)*12 +: 12]    = 12'h020;
        bus.vid_en = 3'b111;
        wait_slot(1);
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (bus.vid_valid !== exp_v[c] || bus.vid_rdata !== exp_d[c] || bus.cpu_ack !== 1'b0) begin
                fails++;
                $display("FAIL vid_ch%0d: valid=%b rdata=%h ack=%b expected %b/%h/0", c, bus.vid_valid,
                         bus.vid_rdata, bus.cpu_ack, exp_v[c], exp_d[c]);
            end
        end
        tick();
        tests++;
        if (bus.vid_valid !== 3'b000 || bus.vid_rdata !== 16'h2222) begin
            fails++; $display("FAIL vid_cpu_slot: valid=%b rdata=%h expected 000/2222", bus.vid_valid, bus.vid_rdata);
        end
        bus.vid_en = 3'b000;
        wait_slot(2);
        tick();
        tests++;
        if (bus.vid_valid !== 3'b000 || bus.vid_rdata !== 16'h2222) begin
            fails++; $display("FAIL vid_disabled: valid=%b rdata=%h expected 000/2222", bus.vid_valid, bus.vid_rdata);
        end
        bus.vid_en = 3'b001;
        cpu_access(1'b1, 12'h010, 16'h5A5A, 2'b11, ack, rd);
        tick();
        tests++;
        if (bus.vid_valid !== 3'b001 || bus.vid_rdata !== 16'h5A5A || bus.cpu_ack !== 1'b0) begin
            fails++; $display("FAIL write_then_fetch: valid=%b rdata=%h ack=%b expected 001/5a5a/0",
                              bus.vid_valid, bus.vid_rdata, bus.cpu_ack);
        end
        bus.vid_en = 3'b000;
    endtask

    task automatic test_latency();
        int n = 0;
        wait_slot(1);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h123;
        do begin
            tick();
            n++;
        end while (bus.cpu_ack !== 1'b1 && n < 10);
        tests++;
        if (n != 4 || bus.cpu_rdata !== 16'hBEAA) begin
            fails++; $display("FAIL latency: cycles=%0d rdata=%h expected 4/beaa", n, bus.cpu_rdata);
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        wait_slot(0);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h020; bus.slot_sync = 1'b1;
        tick();
        bus.slot_sync = 1'b0;
        tests++;
        if (bus.cpu_ack !== 1'b1 || bus.slot !== 2'd0 || bus.cpu_rdata !== 16'h2222) begin
            fails++; $display("FAIL sync_ack: ack=%b slot=%0d rdata=%h expected 1/0/2222",
                              bus.cpu_ack, bus.slot, bus.cpu_rdata);
        end
        tick();
        tests++;
        if (bus.cpu_ack !== 1'b0 || bus.slot !== 2'd1) begin
            fails++; $display("FAIL ack_blocks_reissue: ack=%b slot=%0d expected 0/1", bus.cpu_ack, bus.slot);
        end
        do begin
            tick();
            n++;
        end while (bus.cpu_ack !== 1'b1 && n < 10);
        tests++;
        if (n != 4) begin fails++; $display("FAIL held_req_reissue: cycles=%0d expected 4", n); end
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_sync_and_reset();
        logic ack; logic [15:0] rd;
        wait_slot(1);
        bus.slot_sync = 1'b1;
        tick();
        bus.slot_sync = 1'b0;
        tests++;
        if (bus.slot !== 2'd0) begin fails++; $display("FAIL sync_slot: slot=%0d expected 0", bus.slot); end
        tick();
        tests++;
        if (bus.slot !== 2'd1) begin fails++; $display("FAIL sync_resume: slot=%0d expected 1", bus.slot); end
        wait_slot(0);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h123;
        bus.cpu_wdata = 16'hDEAD; bus.cpu_be = 2'b11; bus.slot_sync = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; bus.cpu_req = 1'b0; bus.slot_sync = 1'b0;
        tests++;
        if (bus.cpu_ack !== 1'b0 || bus.slot !== 2'd0 || bus.cpu_rdata !== 16'h0 || bus.vid_rdata !== 16'h0) begin
            fails++; $display("FAIL rst_pending: ack=%b slot=%0d rdata=%h vrdata=%h expected 0/0/0/0",
                              bus.cpu_ack, bus.slot, bus.cpu_rdata, bus.vid_rdata);
        end
        tick();
        tests++;
        if (bus.cpu_ack !== 1'b0 || bus.slot !== 2'd1) begin
            fails++; $display("FAIL rst_no_ack: ack=%b slot=%0d expected 0/1", bus.cpu_ack, bus.slot);
        end
        cpu_access(1'b0, 12'h123, 16'h0, 2'b00, ack, rd);
        tests++;
        if (ack !== 1'b1 || rd !== 16'hBEAA) begin
            fails++; $display("FAIL data_after_rst: ack=%b rdata=%h expected 1/beaa", ack, rd);
        end
    endtask

    initial begin
        bus.slot_sync = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
        bus.cpu_be = '0; bus.cpu_wdata = '0; bus.vid_en = '0; bus.vid_addr = '0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_video();
        test_latency();
        test_back_to_back();
        test_sync_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
